pc_sequencer: RTL and testbench

//  Sequences every PC update of the multicycle CPU: drives the 3-bit PC-source mux select
//  (000 aluResult, 001 jump address, 010 memData extended, 011 aluOut, 100 EPC) with PCWrite/EPCWrite.

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PC update sequencer for the multicycle CPU: simple PC loads and the exception vector flow.
// Optional handler lock is enabled by defining PCSEQ_EXC_LOCK_EN.
module pc_sequencer #(
    parameter int unsigned MEM_WAIT   = 1,
    parameter logic [7:0]  VEC_OPCODE = 8'd253,
    parameter logic [7:0]  VEC_OVF    = 8'd254,
    parameter logic [7:0]  VEC_DIV0   = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       br_req,
    input  logic       br_taken,
    input  logic       j_req,
    input  logic       jr_req,
    input  logic       rte_req,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       epc_write,
    output logic       exc_mem_sel,
    output logic [7:0] exc_addr,
    output logic [1:0] exc_cause,
    output logic       busy,
    output logic       done,
    output logic       in_handler
);

    typedef enum logic [1:0] {StIdle, StExcSave, StExcRead, StExcLoad} state_e;

    state_e     state;
    logic [3:0] wait_cnt;
    logic       exc_en;
    logic       exc_req;

`ifdef PCSEQ_EXC_LOCK_EN
    // Exceptions raised inside a handler are dropped until rte.
    assign exc_en = ~in_handler;
`else
    assign exc_en     = 1'b1;
    assign in_handler = 1'b0;
`endif

    assign exc_req = exc_en & (exc_opcode | exc_ovf | exc_div0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            wait_cnt    <= 4'd0;
            pc_source   <= 3'b000;
            pc_write    <= 1'b0;
            epc_write   <= 1'b0;
            exc_mem_sel <= 1'b0;
            exc_addr    <= 8'd0;
            exc_cause   <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef PCSEQ_EXC_LOCK_EN
            in_handler  <= 1'b0;
`endif
        end else begin
            pc_write  <= 1'b0;
            epc_write <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (exc_req) begin
                        state     <= StExcSave;
                        busy      <= 1'b1;
                        epc_write <= 1'b1;
                        if (exc_opcode) begin
                            exc_cause <= 2'b01;
                            exc_addr  <= VEC_OPCODE;
                        end else if (exc_ovf) begin
                            exc_cause <= 2'b10;
                            exc_addr  <= VEC_OVF;
                        end else begin
                            exc_cause <= 2'b11;
                            exc_addr  <= VEC_DIV0;
                        end
                    end else if (rte_req) begin
                        pc_source  <= 3'b100;
                        pc_write   <= 1'b1;
                        done       <= 1'b1;
`ifdef PCSEQ_EXC_LOCK_EN
                        in_handler <= 1'b0;
`endif
                    end else if (jr_req) begin
                        pc_source <= 3'b000;
                        pc_write  <= 1'b1;
                        done      <= 1'b1;
                    end else if (j_req) begin
                        pc_source <= 3'b001;
                        pc_write  <= 1'b1;
                        done      <= 1'b1;
                    end else if (br_req) begin
                        pc_source <= br_taken ? 3'b011 : 3'b000;
                        pc_write  <= br_taken;
                        done      <= 1'b1;
                    end else if (fetch_req) begin
                        pc_source <= 3'b000;
                        pc_write  <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                StExcSave: begin
                    state       <= StExcRead;
                    exc_mem_sel <= 1'b1;
                    wait_cnt    <= 4'(MEM_WAIT - 1);
                end
                StExcRead: begin
                    if (wait_cnt == 4'd0) begin
                        state      <= StExcLoad;
                        pc_source  <= 3'b010;
                        pc_write   <= 1'b1;
                        done       <= 1'b1;
`ifdef PCSEQ_EXC_LOCK_EN
                        in_handler <= 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StExcLoad: begin
                    state       <= StIdle;
                    busy        <= 1'b0;
                    exc_mem_sel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random requests checked
// against a transaction-level model of the PC/exception update rules.
module tb_pc_sequencer;

    localparam int unsigned MW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_req, br_req, br_taken, j_req, jr_req, rte_req;
    logic       exc_opcode, exc_ovf, exc_div0;
    logic [2:0] pc_source;
    logic       pc_write, epc_write, exc_mem_sel, busy, done, in_handler;
    logic [7:0] exc_addr;
    logic [1:0] exc_cause;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [2:0] m_src   = 3'b000;
    logic [1:0] m_cause = 2'b00;
    logic [7:0] m_addr  = 8'd0;
    logic       m_inh   = 1'b0;

    pc_sequencer #(.MEM_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .br_req     (br_req),
        .br_taken   (br_taken),
        .j_req      (j_req),
        .jr_req     (jr_req),
        .rte_req    (rte_req),
        .exc_opcode (exc_opcode),
        .exc_ovf    (exc_ovf),
        .exc_div0   (exc_div0),
        .pc_source  (pc_source),
        .pc_write   (pc_write),
        .epc_write  (epc_write),
        .exc_mem_sel(exc_mem_sel),
        .exc_addr   (exc_addr),
        .exc_cause  (exc_cause),
        .busy       (busy),
        .done       (done),
        .in_handler (in_handler)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic pw, input logic epw,
                             input logic sel, input logic bsy, input logic dn);
        chk({tag, ".pc_write"}, {7'd0, pc_write}, {7'd0, pw});
        chk({tag, ".epc_write"}, {7'd0, epc_write}, {7'd0, epw});
        chk({tag, ".pc_source"}, {5'd0, pc_source}, {5'd0, m_src});
        chk({tag, ".exc_mem_sel"}, {7'd0, exc_mem_sel}, {7'd0, sel});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bsy});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, dn});
        chk({tag, ".exc_cause"}, {6'd0, exc_cause}, {6'd0, m_cause});
        chk({tag, ".exc_addr"}, exc_addr, m_addr);
        chk({tag, ".in_handler"}, {7'd0, in_handler}, {7'd0, m_inh});
    endtask

    // r = {exc_opcode, exc_ovf, exc_div0, rte, jr, j, br, br_taken, fetch}
    task automatic drive(input logic [8:0] r);
        {exc_opcode, exc_ovf, exc_div0, rte_req, jr_req, j_req, br_req, br_taken, fetch_req} = r;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_src   = 3'b000;
        m_cause = 2'b00;
        m_addr  = 8'd0;
        m_inh   = 1'b0;
    endtask

    // One request held until its done (or one cycle if nothing is served).
    task automatic run_txn(input logic [8:0] r, input string tag);
        logic       exc_ok;
        logic       pw;
        logic [1:0] cause;
        exc_ok = (|r[8:6]) && !m_inh;
        drive(r);
        step();
        if (exc_ok) begin
            cause   = r[8] ? 2'd1 : (r[7] ? 2'd2 : 2'd3);
            m_cause = cause;
            m_addr  = 8'd252 + 8'(cause);
            check_all({tag, ".save"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < int'(MW); i++) begin
                step();
                check_all({tag, ".read"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            end
            step();
            m_src = 3'b010;
`ifdef PCSEQ_EXC_LOCK_EN
            m_inh = 1'b1;
`endif
            check_all({tag, ".load"}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            drive(9'd0);
            step();
            check_all({tag, ".back_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (|r[5:2] || r[0]) begin
            pw = 1'b1;
            if (r[5]) begin
                m_src = 3'b100;
                m_inh = 1'b0;
            end else if (r[4]) begin
                m_src = 3'b000;
            end else if (r[3]) begin
                m_src = 3'b001;
            end else if (r[2]) begin
                pw    = r[1];
                m_src = r[1] ? 3'b011 : 3'b000;
            end else begin
                m_src = 3'b000;
            end
            check_all({tag, ".simple"}, pw, 1'b0, 1'b0, 1'b0, 1'b1);
            drive(9'd0);
        end else begin
            check_all({tag, ".none"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            drive(9'd0);
        end
    endtask

    initial begin
        logic [8:0] r;
        reset = 1'b1;
        drive(9'b0_0000_0001);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b0;
        drive(9'd0);

        run_txn(9'b000_0000_01, "fetch");
        run_txn(9'b000_0001_00, "br_not_taken");
        run_txn(9'b000_0001_10, "br_taken");
        run_txn(9'b010_0010_00, "ovf_plus_j");
        run_txn(9'b000_0000_00, "idle");
        run_txn(9'b001_0000_00, "div0_after_handler");
        run_txn(9'b000_1000_00, "rte");
        run_txn(9'b000_0100_00, "jr");
        run_txn(9'b111_1111_11, "all_at_once");
        run_txn(9'b000_1000_00, "rte2");

        // Reset while waiting on the vector read
        drive(9'b100_0000_00);
        step();
        m_cause = 2'd1;
        m_addr  = 8'd253;
        check_all("rst_mid.save", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check_all("rst_mid.read", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        model_reset();
        check_all("rst_mid.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(9'd0);
        step();
        check_all("rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            r = 9'd0;
            for (int b = 0; b < 6; b++) r[b] = ($urandom_range(0, 3) == 0);
            for (int b = 6; b < 9; b++) r[b] = ($urandom_range(0, 9) == 0);
            run_txn(r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
